// File: rtl/spm_port_cache_if.sv
// Request/response channel between spm_port_cache and the external-memory bridge.
// A request moves on any mod_clk edge where mem_req_valid && mem_req_ready; once raised, valid holds with a stable payload until then.
interface spm_port_cache_if #(
    parameter int ADDR_WID = 13,
    parameter int DATA_WID = 32
);
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic                mem_req_we;
    logic [ADDR_WID-1:0] mem_req_addr;
    logic [DATA_WID-1:0] mem_req_wdata;
    logic                mem_rsp_valid;
    logic [DATA_WID-1:0] mem_rsp_data;

    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );
endinterface

// File: rtl/spm_port_cache.sv
// Direct-mapped write-through cache in front of the HLS kernel's two scratchpad ports; stalls the kernel via kernel_ce.
// Optional hit/miss counters are enabled by defining SPM_STATS_EN.
module spm_port_cache #(
    parameter int ADDR_WID = 13,
    parameter int DATA_WID = 32,
    parameter int IDX_WID  = 6
) (
    input  logic                mod_clk,
    input  logic                reset,
    input  logic [ADDR_WID-1:0] p0_address,
    input  logic                p0_ce,
    input  logic                p0_we,
    input  logic [DATA_WID-1:0] p0_d,
    output logic [DATA_WID-1:0] p0_q,
    input  logic [ADDR_WID-1:0] p1_address,
    input  logic                p1_ce,
    input  logic                p1_we,
    input  logic [DATA_WID-1:0] p1_d,
    output logic [DATA_WID-1:0] p1_q,
    output logic                kernel_ce,
    spm_port_cache_if.master    mem,
    output logic [2:0]          fsm_state
`ifdef SPM_STATS_EN
    ,
    output logic [31:0]         stat_hits,
    output logic [31:0]         stat_misses
`endif
);
    localparam int TAG_WID = ADDR_WID - IDX_WID;
    localparam int LINES   = 1 << IDX_WID;

    localparam logic [2:0] ST_RUN    = 3'd0;
    localparam logic [2:0] ST_SVC0   = 3'd1;
    localparam logic [2:0] ST_WAIT0  = 3'd2;
    localparam logic [2:0] ST_SVC1   = 3'd3;
    localparam logic [2:0] ST_WAIT1  = 3'd4;
    localparam logic [2:0] ST_RESUME = 3'd5;

    logic [2:0] state;

    logic [LINES-1:0]   valid_arr;
    logic [TAG_WID-1:0] tag_arr  [LINES];
    logic [DATA_WID-1:0] data_arr [LINES];

    // Port requests captured at the edge that froze the kernel.
    logic                c0_ce, c0_we, c1_ce, c1_we;
    logic [ADDR_WID-1:0] c0_addr, c1_addr;
    logic [DATA_WID-1:0] c0_d, c1_d;

    logic                req_valid, req_we;
    logic [ADDR_WID-1:0] req_addr;
    logic [DATA_WID-1:0] req_wdata;

    logic [IDX_WID-1:0] idx0, idx1, svc_idx, line_idx;
    logic [TAG_WID-1:0] tag0, tag1, svc_tag, line_tag;
    logic               hit0, hit1, need0, need1, any_need;
    logic               svc_port1, in_svc, svc_ce, svc_we, svc_hit, svc_need;
    logic [ADDR_WID-1:0] svc_addr;
    logic [DATA_WID-1:0] svc_d, line_data;
    logic               line_we;

    assign fsm_state         = state;
    assign mem.mem_req_valid = req_valid;
    assign mem.mem_req_we    = req_we;
    assign mem.mem_req_addr  = req_addr;
    assign mem.mem_req_wdata = req_wdata;

    always_comb begin
        idx0     = p0_address[IDX_WID-1:0];
        tag0     = p0_address[ADDR_WID-1:IDX_WID];
        idx1     = p1_address[IDX_WID-1:0];
        tag1     = p1_address[ADDR_WID-1:IDX_WID];
        hit0     = valid_arr[idx0] && (tag_arr[idx0] == tag0);
        hit1     = valid_arr[idx1] && (tag_arr[idx1] == tag1);
        need0    = p0_ce && (p0_we || !hit0);
        need1    = p1_ce && (p1_we || !hit1);
        any_need = need0 || need1;

        // Service-side lookup sees any line update port 0 already made.
        svc_port1 = (state == ST_SVC1) || (state == ST_WAIT1);
        in_svc    = (state == ST_SVC0) || (state == ST_SVC1);
        svc_ce    = svc_port1 ? c1_ce   : c0_ce;
        svc_we    = svc_port1 ? c1_we   : c0_we;
        svc_addr  = svc_port1 ? c1_addr : c0_addr;
        svc_d     = svc_port1 ? c1_d    : c0_d;
        svc_idx   = svc_addr[IDX_WID-1:0];
        svc_tag   = svc_addr[ADDR_WID-1:IDX_WID];
        svc_hit   = valid_arr[svc_idx] && (tag_arr[svc_idx] == svc_tag);
        svc_need  = svc_ce && (svc_we || !svc_hit);

        line_we   = 1'b0;
        line_idx  = svc_idx;
        line_tag  = svc_tag;
        line_data = svc_d;
        if (in_svc && !req_valid && svc_ce && svc_we) begin
            line_we = 1'b1;
        end else if (((state == ST_WAIT0) || (state == ST_WAIT1)) && mem.mem_rsp_valid) begin
            line_we   = 1'b1;
            line_data = mem.mem_rsp_data;
        end
    end

    always_ff @(posedge mod_clk) begin
        if (line_we) begin
            tag_arr[line_idx]  <= line_tag;
            data_arr[line_idx] <= line_data;
        end
    end

    always_ff @(posedge mod_clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            kernel_ce <= 1'b1;
            valid_arr <= '0;
            req_valid <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            p0_q      <= '0;
            p1_q      <= '0;
            c0_ce     <= 1'b0;
            c0_we     <= 1'b0;
            c0_addr   <= '0;
            c0_d      <= '0;
            c1_ce     <= 1'b0;
            c1_we     <= 1'b0;
            c1_addr   <= '0;
            c1_d      <= '0;
        end else begin
            if (line_we) valid_arr[line_idx] <= 1'b1;
            case (state)
                ST_RUN: begin
                    if (any_need) begin
                        c0_ce     <= p0_ce;
                        c0_we     <= p0_we;
                        c0_addr   <= p0_address;
                        c0_d      <= p0_d;
                        c1_ce     <= p1_ce;
                        c1_we     <= p1_we;
                        c1_addr   <= p1_address;
                        c1_d      <= p1_d;
                        kernel_ce <= 1'b0;
                        state     <= ST_SVC0;
                        if (p0_ce && !p0_we) p0_q <= data_arr[idx0];
                    end else begin
                        if (p0_ce) p0_q <= data_arr[idx0];
                        if (p1_ce) p1_q <= data_arr[idx1];
                    end
                end
                ST_SVC0, ST_SVC1: begin
                    if (req_valid) begin
                        if (mem.mem_req_ready) begin
                            req_valid <= 1'b0;
                            if (req_we) state <= svc_port1 ? ST_RESUME : ST_SVC1;
                            else        state <= svc_port1 ? ST_WAIT1  : ST_WAIT0;
                        end
                    end else if (svc_need) begin
                        req_valid <= 1'b1;
                        req_we    <= svc_we;
                        req_addr  <= svc_addr;
                        req_wdata <= svc_d;
                    end else begin
                        if (svc_port1 && svc_ce) p1_q <= data_arr[svc_idx];
                        state <= svc_port1 ? ST_RESUME : ST_SVC1;
                    end
                end
                ST_WAIT0: begin
                    if (mem.mem_rsp_valid) begin
                        p0_q  <= mem.mem_rsp_data;
                        state <= ST_SVC1;
                    end
                end
                ST_WAIT1: begin
                    if (mem.mem_rsp_valid) begin
                        p1_q  <= mem.mem_rsp_data;
                        state <= ST_RESUME;
                    end
                end
                ST_RESUME: begin
                    kernel_ce <= 1'b1;
                    state     <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

`ifdef SPM_STATS_EN
    logic [1:0]  hit_inc, miss_inc;
    logic [32:0] hits_sum, misses_sum;

    always_comb begin
        hit_inc  = 2'd0;
        miss_inc = 2'd0;
        if (state == ST_RUN) begin
            hit_inc = {1'b0, p0_ce && !p0_we && hit0} + {1'b0, !any_need && p1_ce && !p1_we};
        end else if (in_svc && !req_valid) begin
            if (svc_need && !svc_we)                  miss_inc = 2'd1;
            if (svc_port1 && !svc_need && svc_ce)      hit_inc  = 2'd1;
        end
        hits_sum   = {1'b0, stat_hits}   + {31'd0, hit_inc};
        misses_sum = {1'b0, stat_misses} + {31'd0, miss_inc};
    end

    always_ff @(posedge mod_clk or posedge reset) begin
        if (reset) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else begin
            stat_hits   <= hits_sum[32]   ? 32'hFFFF_FFFF : hits_sum[31:0];
            stat_misses <= misses_sum[32] ? 32'hFFFF_FFFF : misses_sum[31:0];
        end
    end
`endif
endmodule

// File: tb/tb_spm_port_cache.sv
// Self-checking bench for spm_port_cache: kernel-side driver, bridge model with a backing memory, scoreboard of expected read data.
module tb_spm_port_cache;
  localparam int AW = 13;
  localparam int DW = 32;

  logic          mod_clk, reset;
  logic [AW-1:0] p0_address, p1_address;
  logic          p0_ce, p0_we, p1_ce, p1_we;
  logic [DW-1:0] p0_d, p1_d, p0_q, p1_q;
  logic          kernel_ce;
  logic [2:0]    fsm_state;
`ifdef SPM_STATS_EN
  logic [31:0]   stat_hits, stat_misses;
`endif

  spm_port_cache_if #(.ADDR_WID(AW), .DATA_WID(DW)) bus ();

  spm_port_cache #(.ADDR_WID(AW), .DATA_WID(DW), .IDX_WID(6)) dut (
    .mod_clk(mod_clk), .reset(reset),
    .p0_address(p0_address), .p0_ce(p0_ce), .p0_we(p0_we), .p0_d(p0_d), .p0_q(p0_q),
    .p1_address(p1_address), .p1_ce(p1_ce), .p1_we(p1_we), .p1_d(p1_d), .p1_q(p1_q),
    .kernel_ce(kernel_ce), .mem(bus), .fsm_state(fsm_state)
`ifdef SPM_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  // clock / reset
  initial begin
    mod_clk = 1'b0;
    forever #5 mod_clk = ~mod_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard and reference state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] ext_mem [0:(1<<AW)-1];
  logic [DW-1:0] last_q0, last_q1;
  int total, bad;

  // bridge model state
  int            n_rd, n_wr, n_valid_cycles;
  int            stall_cnt, stall_seen, rsp_timer;
  logic          unstable;
  logic          first_we;
  logic [AW-1:0] first_addr, rd_addr;
  logic [DW-1:0] first_wdata;

  initial begin
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    forever begin
      @(negedge mod_clk);
      if (reset) begin
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        rsp_timer = 0;
        stall_cnt = 0;
      end else begin
        bus.mem_rsp_valid = 1'b0;
        if (rsp_timer > 0) begin
          rsp_timer--;
          if (rsp_timer == 0) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = ext_mem[rd_addr];
          end
        end
        if (bus.mem_req_valid) begin
          n_valid_cycles++;
          if (stall_seen == 0) begin
            first_we = bus.mem_req_we; first_addr = bus.mem_req_addr; first_wdata = bus.mem_req_wdata;
          end else if (bus.mem_req_we !== first_we || bus.mem_req_addr !== first_addr ||
                       bus.mem_req_wdata !== first_wdata) begin
            unstable = 1'b1;
          end
          if (stall_cnt > 0) begin
            bus.mem_req_ready = 1'b0;
            stall_cnt--;
            stall_seen++;
          end else begin
            bus.mem_req_ready = 1'b1;
            stall_seen = 0;
            if (bus.mem_req_we) begin
              ext_mem[bus.mem_req_addr] = bus.mem_req_wdata;
              n_wr++;
            end else begin
              rd_addr = bus.mem_req_addr;
              rsp_timer = 2;
              n_rd++;
            end
          end
        end else begin
          bus.mem_req_ready = 1'b0;
        end
      end
    end
  end

  // driver: one kernel access, returns whether the kernel was frozen
  task automatic do_access(input logic ce0, input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                           input logic ce1, input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                           output logic stalled);
    int n;
    logic [DW-1:0] e;
    p0_ce = ce0; p0_we = we0; p0_address = a0; p0_d = d0;
    p1_ce = ce1; p1_we = we1; p1_address = a1; p1_d = d1;
    if (ce0 && !we0) exp_q.push_back(ref_mem[a0]);
    if (ce0 && we0)  ref_mem[a0] = d0;
    if (ce1 && !we1) exp_q.push_back(ref_mem[a1]);
    if (ce1 && we1)  ref_mem[a1] = d1;
    @(posedge mod_clk);
    @(negedge mod_clk);
    stalled = !kernel_ce;
    p0_ce = 1'b0; p1_ce = 1'b0; p0_we = 1'b0; p1_we = 1'b0;
    n = 0;
    while (kernel_ce !== 1'b1 && n < 200) begin
      @(negedge mod_clk);
      n++;
    end
    total++;
    if (kernel_ce !== 1'b1) begin
      bad++;
      $display("FAIL access_timeout: kernel_ce=%b required 1", kernel_ce);
    end
    if (ce0 && !we0) begin
      e = exp_q.pop_front();
      last_q0 = e;
    end else begin
      e = last_q0;
    end
    if (ce0 && we0) e = p0_q;
    else begin
      total++;
      if (p0_q !== e) begin bad++; $display("FAIL p0_q a0=%0d: got %h required %h", a0, p0_q, e); end
    end
    if (ce1 && !we1) begin
      e = exp_q.pop_front();
      last_q1 = e;
    end else begin
      e = last_q1;
    end
    if (!(ce1 && we1)) begin
      total++;
      if (p1_q !== e) begin bad++; $display("FAIL p1_q a1=%0d: got %h required %h", a1, p1_q, e); end
    end
  endtask

  task automatic rd0(input logic [AW-1:0] a, output logic stalled);
    do_access(1'b1, 1'b0, a, '0, 1'b0, 1'b0, '0, '0, stalled);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    p0_ce = 0; p0_we = 0; p0_address = '0; p0_d = '0;
    p1_ce = 0; p1_we = 0; p1_address = '0; p1_d = '0;
    repeat (3) @(posedge mod_clk);
    #1;
    total++; if (kernel_ce !== 1'b1) begin bad++; $display("FAIL reset_kernel_ce: got %b required 1", kernel_ce); end
    total++; if (bus.mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b required 0", bus.mem_req_valid); end
    total++; if ({bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata} !== '0) begin
      bad++; $display("FAIL reset_req_payload: we=%b addr=%h wdata=%h required zero", bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata);
    end
    total++; if (p0_q !== '0 || p1_q !== '0) begin bad++; $display("FAIL reset_q: p0_q=%h p1_q=%h required 0", p0_q, p1_q); end
    total++; if (fsm_state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d required 0", fsm_state); end
    @(negedge mod_clk);
    reset = 1'b0;
    last_q0 = '0; last_q1 = '0;
  endtask

  task automatic test_cold_read;
    logic st;
    int r0, v0;
    r0 = n_rd;
    rd0(13'd5, st);
    total++; if (st !== 1'b1) begin bad++; $display("FAIL cold_read_stall: got %b required 1", st); end
    total++; if (n_rd - r0 != 1) begin bad++; $display("FAIL cold_read_reqs: got %0d required 1", n_rd - r0); end
    r0 = n_rd; v0 = n_valid_cycles;
    rd0(13'd5, st);
    total++; if (st !== 1'b0) begin bad++; $display("FAIL hit_read_stall: got %b required 0", st); end
    total++; if (n_valid_cycles != v0) begin bad++; $display("FAIL hit_read_req_valid: got %0d cycles required 0", n_valid_cycles - v0); end
  endtask

  task automatic test_write_stall;
    logic st;
    int w0, r0;
    w0 = n_wr; unstable = 1'b0; stall_seen = 0;
    stall_cnt = 3;
    do_access(1'b1, 1'b1, 13'd7, 32'h11, 1'b0, 1'b0, '0, '0, st);
    total++; if (n_wr - w0 != 1) begin bad++; $display("FAIL write_count: got %0d required 1", n_wr - w0); end
    total++; if (unstable !== 1'b0) begin bad++; $display("FAIL write_payload_stable: unstable=%b required 0", unstable); end
    total++; if (ext_mem[7] !== 32'h11) begin bad++; $display("FAIL write_data: got %h required 00000011", ext_mem[7]); end
    r0 = n_rd;
    rd0(13'd7, st);
    total++; if (st !== 1'b0 || n_rd != r0) begin bad++; $display("FAIL write_then_hit: stall=%b reads=%0d required 0 0", st, n_rd - r0); end
  endtask

  task automatic test_same_edge;
    logic st;
    int w0, r0;
    w0 = n_wr; r0 = n_rd;
    do_access(1'b1, 1'b1, 13'd9, 32'hA, 1'b1, 1'b0, 13'd9, '0, st);
    total++; if (n_wr - w0 != 1 || n_rd != r0) begin
      bad++; $display("FAIL same_edge_reqs: writes=%0d reads=%0d required 1 0", n_wr - w0, n_rd - r0);
    end
    w0 = n_wr; r0 = n_rd;
    do_access(1'b1, 1'b1, 13'd11, 32'h1234, 1'b1, 1'b1, 13'd11, 32'h5678, st);
    total++; if (n_wr - w0 != 2 || ext_mem[11] !== 32'h5678) begin
      bad++; $display("FAIL both_write: writes=%0d mem=%h required 2 00005678", n_wr - w0, ext_mem[11]);
    end
    do_access(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 13'd11, '0, st);
    total++; if (n_rd != r0) begin bad++; $display("FAIL both_write_hit: reads=%0d required 0", n_rd - r0); end
  endtask

  task automatic test_evict;
    logic st;
    int r0;
    r0 = n_rd;
    rd0(13'd5, st);
    rd0(13'd69, st);
    total++; if (n_rd - r0 != 1) begin bad++; $display("FAIL evict_second_miss: reads=%0d required 1", n_rd - r0); end
    rd0(13'd5, st);
    total++; if (n_rd - r0 != 2 || st !== 1'b1) begin bad++; $display("FAIL evict_remiss: reads=%0d stall=%b required 2 1", n_rd - r0, st); end
  endtask

`ifdef SPM_STATS_EN
  task automatic test_stats;
    logic st;
    logic [31:0] h0, m0;
    h0 = stat_hits; m0 = stat_misses;
    rd0(13'd5, st);
    rd0(13'd69, st);
    rd0(13'd69, st);
    total++; if (stat_hits - h0 != 32'd2) begin bad++; $display("FAIL stat_hits: got %0d required 2", stat_hits - h0); end
    total++; if (stat_misses - m0 != 32'd1) begin bad++; $display("FAIL stat_misses: got %0d required 1", stat_misses - m0); end
  endtask
`endif

  task automatic test_back_to_back;
    logic st;
    logic c0, w0, c1, w1;
    logic [AW-1:0] a0, a1;
    for (int i = 0; i < 40; i++) begin
      c0 = 1'($urandom_range(0, 1)); w0 = 1'($urandom_range(0, 1));
      c1 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
      a0 = AW'($urandom_range(0, 1) * 64 + $urandom_range(16, 23));
      a1 = AW'($urandom_range(0, 1) * 64 + $urandom_range(16, 23));
      do_access(c0, w0, a0, $urandom, c1, w1, a1, $urandom, st);
    end
  endtask

  task automatic test_reset_mid_run;
    logic st;
    int r0;
    rd0(13'd0, st);
    r0 = n_rd;
    rd0(13'd0, st);
    total++; if (n_rd != r0) begin bad++; $display("FAIL pre_reset_hit: reads=%0d required 0", n_rd - r0); end
    stall_cnt = 50;
    p0_ce = 1'b1; p0_we = 1'b0; p0_address = 13'd200;
    @(posedge mod_clk);
    @(negedge mod_clk);
    p0_ce = 1'b0;
    repeat (2) @(negedge mod_clk);
    total++; if (kernel_ce !== 1'b0 || bus.mem_req_valid !== 1'b1) begin
      bad++; $display("FAIL mid_run_pending: kernel_ce=%b valid=%b required 0 1", kernel_ce, bus.mem_req_valid);
    end
    reset = 1'b1;
    stall_cnt = 0; rsp_timer = 0;
    #1;
    total++; if (kernel_ce !== 1'b1 || bus.mem_req_valid !== 1'b0) begin
      bad++; $display("FAIL mid_reset_ctrl: kernel_ce=%b valid=%b required 1 0", kernel_ce, bus.mem_req_valid);
    end
    total++; if (p0_q !== '0 || p1_q !== '0) begin bad++; $display("FAIL mid_reset_q: p0_q=%h p1_q=%h required 0", p0_q, p1_q); end
    @(negedge mod_clk);
    @(negedge mod_clk);
    reset = 1'b0;
    last_q0 = '0; last_q1 = '0;
    r0 = n_rd;
    rd0(13'd0, st);
    total++; if (n_rd - r0 != 1 || st !== 1'b1) begin bad++; $display("FAIL post_reset_miss: reads=%0d stall=%b required 1 1", n_rd - r0, st); end
  endtask

  initial begin
    total = 0; bad = 0;
    n_rd = 0; n_wr = 0; n_valid_cycles = 0;
    stall_cnt = 0; stall_seen = 0; rsp_timer = 0; unstable = 1'b0;
    for (int i = 0; i < (1 << AW); i++) begin
      ext_mem[i] = 32'hA500_0000 | i;
      ref_mem[i] = 32'hA500_0000 | i;
    end
    ext_mem[5] = 32'hDEAD;
    ref_mem[5] = 32'hDEAD;
    test_reset();
    test_cold_read();
    test_write_stall();
    test_same_edge();
    test_evict();
`ifdef SPM_STATS_EN
    test_stats();
`endif
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
